// File: rtl/pmod_qspi_io_stage.sv
// pmod_qspi_io_stage: registered QSPI pad drive, synchronised/tapped DQ inputs and CSN guard timing.
// Define PMOD_QSPI_IO_LOOPBACK_EN to add i_loopback, which routes the registered DQ drives back into the synchronisers.
module pmod_qspi_io_stage #(
    parameter int parm_lane_count       = 4,
    parameter int parm_sync_stages      = 2,
    parameter int parm_max_sample_delay = 3,
    parameter int parm_csn_guard_cycles = 4
) (
    input  logic                       i_clk_mhz,
    input  logic                       i_rstn_mhz,
    input  logic                       i_ce_mhz_div,
    input  logic                       i_fsm_sck_o,
    input  logic                       i_fsm_sck_t,
    input  logic                       i_fsm_csn_o,
    input  logic                       i_fsm_csn_t,
    input  logic [parm_lane_count-1:0] i_fsm_dq_o,
    input  logic [parm_lane_count-1:0] i_fsm_dq_t,
    output logic [parm_lane_count-1:0] o_fsm_dq_i,
    input  logic [2:0]                 i_sample_delay,
`ifdef PMOD_QSPI_IO_LOOPBACK_EN
    input  logic                       i_loopback,
`endif
    output logic                       o_bus_ready,
    output logic                       o_guard_violation,
    output logic                       eio_sck_o,
    output logic                       eio_sck_t,
    output logic                       eio_csn_o,
    output logic                       eio_csn_t,
    output logic [parm_lane_count-1:0] eio_dq_o,
    output logic [parm_lane_count-1:0] eio_dq_t,
    input  logic [parm_lane_count-1:0] eio_dq_i
);
    localparam int         lp_depth   = parm_sync_stages + parm_max_sample_delay;
    localparam logic [7:0] lp_guard   = 8'(parm_csn_guard_cycles);
    localparam logic [2:0] lp_max_sel = 3'(parm_max_sample_delay);

    typedef enum logic [1:0] {ST_HOLD, ST_IDLE, ST_SELECTED, ST_GUARD} state_t;

    state_t                     r_state;
    logic [7:0]                 r_guard_cnt;
    logic                       r_bus_ready;
    logic                       r_guard_violation;
    logic                       r_sck_o, r_sck_t, r_csn_o, r_csn_t;
    logic [parm_lane_count-1:0] r_dq_o, r_dq_t, r_dq_i;
    logic [parm_lane_count-1:0] r_pipe [lp_depth];
    logic                       w_guarding, w_guard_done, w_loopback;
    logic [2:0]                 w_sel;
    logic [parm_lane_count-1:0] w_dq_src, w_tap;

`ifdef PMOD_QSPI_IO_LOOPBACK_EN
    assign w_loopback = i_loopback;
`else
    assign w_loopback = 1'b0;
`endif

    assign w_guarding   = (r_state == ST_HOLD) || (r_state == ST_GUARD);
    assign w_guard_done = w_guarding && (r_guard_cnt == 8'd1);
    assign w_dq_src     = w_loopback ? r_dq_o : eio_dq_i;
    assign w_sel        = (i_sample_delay > lp_max_sel) ? lp_max_sel : i_sample_delay;

    // Synchroniser and delay chain share one shift register; tap 0 is the last synchroniser flop.
    always_comb begin
        w_tap = r_pipe[parm_sync_stages-1];
        for (int k = 1; k <= parm_max_sample_delay; k++)
            if (w_sel == 3'(k)) w_tap = r_pipe[parm_sync_stages-1+k];
    end

    always_ff @(posedge i_clk_mhz) begin
        if (!i_rstn_mhz) begin
            r_sck_o <= 1'b0;
            r_sck_t <= 1'b0;
            r_csn_o <= 1'b1;
            r_csn_t <= 1'b0;
            r_dq_o  <= '0;
            r_dq_t  <= '1;
            r_dq_i  <= '0;
            for (int k = 0; k < lp_depth; k++) r_pipe[k] <= '0;
        end else if (i_ce_mhz_div) begin
            r_sck_o   <= i_fsm_sck_o;
            r_sck_t   <= i_fsm_sck_t;
            r_csn_o   <= i_fsm_csn_o | w_guarding;
            r_csn_t   <= i_fsm_csn_t;
            r_dq_o    <= i_fsm_dq_o;
            r_dq_t    <= i_fsm_dq_t | {parm_lane_count{w_loopback}};
            r_pipe[0] <= w_dq_src;
            for (int k = 1; k < lp_depth; k++) r_pipe[k] <= r_pipe[k-1];
            r_dq_i    <= w_tap;
        end
    end

    // A select request landing on the final guard cycle is legal: it is honoured one CE-cycle later from ST_IDLE.
    always_ff @(posedge i_clk_mhz) begin
        if (!i_rstn_mhz) begin
            r_state           <= ST_HOLD;
            r_guard_cnt       <= lp_guard;
            r_bus_ready       <= 1'b0;
            r_guard_violation <= 1'b0;
        end else if (i_ce_mhz_div) begin
            if (w_guarding && !i_fsm_csn_o && !w_guard_done) r_guard_violation <= 1'b1;
            case (r_state)
                ST_HOLD, ST_GUARD: begin
                    if (w_guard_done) begin
                        r_state     <= ST_IDLE;
                        r_bus_ready <= 1'b1;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (!i_fsm_csn_o) begin
                        r_state     <= ST_SELECTED;
                        r_bus_ready <= 1'b0;
                    end
                end
                default: begin
                    if (i_fsm_csn_o) begin
                        r_state     <= ST_GUARD;
                        r_guard_cnt <= lp_guard;
                    end
                end
            endcase
        end
    end

    assign eio_sck_o         = r_sck_o;
    assign eio_sck_t         = r_sck_t;
    assign eio_csn_o         = r_csn_o;
    assign eio_csn_t         = r_csn_t;
    assign eio_dq_o          = r_dq_o;
    assign eio_dq_t          = r_dq_t;
    assign o_fsm_dq_i        = r_dq_i;
    assign o_bus_ready       = r_bus_ready;
    assign o_guard_violation = r_guard_violation;
endmodule

// File: tb/tb_pmod_qspi_io_stage.sv
// tb_pmod_qspi_io_stage: directed stimulus with cycle-tagged expectations checked by a scoreboard monitor.
module tb_pmod_qspi_io_stage;
  logic       clk = 1'b0, rstn = 1'b0, ce = 1'b1;
  logic       sck_o = 1'b1, sck_t = 1'b0, csn_o = 1'b1, csn_t = 1'b0;
  logic [3:0] dq_o = 4'h5, dq_t = 4'hF, pad_i = 4'h0;
  logic [2:0] sdly = 3'd0;
  logic [3:0] fsm_dq_i, e_dq_o, e_dq_t;
  logic       bus_ready, viol, e_sck_o, e_sck_t, e_csn_o, e_csn_t;
`ifdef PMOD_QSPI_IO_LOOPBACK_EN
  logic       lb = 1'b0;
`endif
  typedef struct {int cyc; int sig; logic [3:0] exp; string name;} exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, errors = 0;
  pmod_qspi_io_stage dut (
    .i_clk_mhz(clk), .i_rstn_mhz(rstn), .i_ce_mhz_div(ce),
    .i_fsm_sck_o(sck_o), .i_fsm_sck_t(sck_t), .i_fsm_csn_o(csn_o), .i_fsm_csn_t(csn_t),
    .i_fsm_dq_o(dq_o), .i_fsm_dq_t(dq_t), .o_fsm_dq_i(fsm_dq_i), .i_sample_delay(sdly),
`ifdef PMOD_QSPI_IO_LOOPBACK_EN
    .i_loopback(lb),
`endif
    .o_bus_ready(bus_ready), .o_guard_violation(viol),
    .eio_sck_o(e_sck_o), .eio_sck_t(e_sck_t), .eio_csn_o(e_csn_o), .eio_csn_t(e_csn_t),
    .eio_dq_o(e_dq_o), .eio_dq_t(e_dq_t), .eio_dq_i(pad_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [3:0] sample(input int s);
    case (s)
      0: return {3'b0, bus_ready};
      1: return {3'b0, e_csn_o};
      2: return {3'b0, viol};
      3: return fsm_dq_i;
      4: return e_dq_t;
      5: return {3'b0, e_sck_o};
      6: return {3'b0, e_sck_t};
      7: return {3'b0, e_csn_t};
      default: return e_dq_o;
    endcase
  endfunction
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if (sample(sb[i].sig) !== sb[i].exp) begin
          errors++;
          $display("FAIL %s at cycle %0d: got %h expected %h", sb[i].name, cyc, sample(sb[i].sig), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end
  task automatic push_exp(input int d, input int s, input logic [3:0] v, input string n);
    sb.push_back('{cyc + d, s, v, n});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ce_group();
    ce = 1'b1;
    tick(1);
    ce = 1'b0;
    tick(3);
  endtask
  logic [3:0] pat [7] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h5, 4'h3};
  logic [2:0] sds [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd1, 3'd5};
  logic [13:0] ovec [3] = '{{1'b0, 1'b1, 1'b1, 4'hA, 4'h3, 3'b0}, {1'b1, 1'b0, 1'b0, 4'h6, 4'hC, 3'b0}, {1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 3'b0}};
  initial begin
    tick(2);
    checks++;
    if (e_csn_o !== 1'b1) begin
      errors++;
      $display("FAIL direct_rst_csn_o: got %b", e_csn_o);
    end
    checks++;
    if (e_dq_t !== 4'hF) begin
      errors++;
      $display("FAIL direct_rst_dq_t: got %h", e_dq_t);
    end
    checks++;
    if (fsm_dq_i !== 4'h0) begin
      errors++;
      $display("FAIL direct_rst_fsm_dq_i: got %h", fsm_dq_i);
    end
    push_exp(0, 0, 4'h0, "rst_bus_ready");
    push_exp(0, 1, 4'h1, "rst_csn_o");
    push_exp(0, 2, 4'h0, "rst_violation");
    push_exp(0, 3, 4'h0, "rst_fsm_dq_i");
    push_exp(0, 4, 4'hF, "rst_dq_t");
    push_exp(0, 5, 4'h0, "rst_sck_o");
    push_exp(0, 7, 4'h0, "rst_csn_t");
    push_exp(0, 8, 4'h0, "rst_dq_o");
    rstn = 1'b1;
    push_exp(1, 0, 4'h0, "hold_ready_c1");
    push_exp(3, 0, 4'h0, "hold_ready_c3");
    push_exp(4, 0, 4'h1, "hold_ready_c4");
    push_exp(2, 1, 4'h1, "hold_csn_c2");
    push_exp(4, 1, 4'h1, "hold_csn_c4");
    push_exp(1, 5, 4'h1, "sck_o_lat");
    push_exp(1, 8, 4'h5, "dq_o_lat");
    tick(4);
    for (int i = 0; i < 3; i++) begin
      {sck_o, sck_t, csn_t, dq_o, dq_t} = ovec[i][13:3];
      push_exp(1, 5, {3'b0, ovec[i][13]}, "vec_sck_o");
      push_exp(1, 6, {3'b0, ovec[i][12]}, "vec_sck_t");
      push_exp(1, 7, {3'b0, ovec[i][11]}, "vec_csn_t");
      push_exp(1, 8, ovec[i][10:7], "vec_dq_o");
      push_exp(1, 4, ovec[i][6:3], "vec_dq_t");
      tick(1);
    end
    csn_o = 1'b0;
    push_exp(0, 0, 4'h1, "idle_ready");
    push_exp(1, 1, 4'h0, "sel_csn_lag");
    push_exp(1, 0, 4'h0, "sel_ready");
    push_exp(5, 1, 4'h0, "sel_csn_mid");
    tick(10);
    csn_o = 1'b1;
    push_exp(1, 1, 4'h1, "desel_csn");
    push_exp(1, 0, 4'h0, "guard_ready_c1");
    push_exp(4, 0, 4'h0, "guard_ready_c4");
    push_exp(5, 0, 4'h1, "guard_ready_c5");
    tick(3);
    csn_o = 1'b0;
    push_exp(1, 2, 4'h1, "viol_set");
    push_exp(1, 1, 4'h1, "viol_csn_masked1");
    push_exp(2, 1, 4'h1, "viol_csn_masked2");
    push_exp(3, 1, 4'h0, "viol_csn_after");
    push_exp(10, 2, 4'h1, "viol_sticky");
    tick(10);
    rstn = 1'b0;
    push_exp(1, 1, 4'h1, "midrst_csn");
    push_exp(1, 2, 4'h0, "midrst_viol_clr");
    push_exp(1, 0, 4'h0, "midrst_ready");
    tick(1);
    csn_o = 1'b1;
    tick(1);
    rstn = 1'b1;
    tick(3);
    csn_o = 1'b0;
    push_exp(1, 2, 4'h0, "simul_no_viol");
    push_exp(1, 0, 4'h1, "simul_ready");
    push_exp(1, 1, 4'h1, "simul_csn_c1");
    push_exp(2, 1, 4'h0, "simul_csn_c2");
    push_exp(2, 0, 4'h0, "simul_sel");
    push_exp(3, 2, 4'h0, "simul_no_viol_c3");
    tick(3);
    csn_o = 1'b1;
    tick(6);
    for (int i = 0; i < 7; i++) begin
      int lat;
      lat = 3 + ((sds[i] > 3'd3) ? 3 : int'(sds[i]));
      pad_i = pat[i];
      sdly = sds[i];
      push_exp(lat - 1, 3, 4'h0, "tap_before");
      push_exp(lat, 3, pat[i], "tap_pulse");
      push_exp(lat + 1, 3, 4'h0, "tap_after");
      tick(1);
      pad_i = 4'h0;
      tick(lat + 2);
    end
    sdly = 3'd0;
    rstn = 1'b0;
    ce = 1'b0;
    tick(2);
    push_exp(0, 0, 4'h0, "ce_rst_ready");
    rstn = 1'b1;
    push_exp(12, 0, 4'h0, "ce_hold_c12");
    push_exp(13, 0, 4'h1, "ce_hold_c13");
    push_exp(16, 0, 4'h1, "ce_hold_c16");
    repeat (4) ce_group();
    ce = 1'b1;
    tick(1);
    ce = 1'b0;
    csn_o = 1'b0;
    push_exp(2, 1, 4'h1, "ce_low_csn_hold");
    push_exp(2, 0, 4'h1, "ce_low_ready_hold");
    push_exp(2, 2, 4'h0, "ce_low_no_viol");
    tick(2);
    csn_o = 1'b1;
    tick(1);
    csn_o = 1'b0;
    push_exp(1, 1, 4'h0, "ce_sel_csn");
    push_exp(4, 1, 4'h0, "ce_sel_csn_held");
    push_exp(1, 0, 4'h0, "ce_sel_ready");
    ce_group();
    csn_o = 1'b1;
    push_exp(1, 1, 4'h1, "ce_desel_csn");
    push_exp(16, 0, 4'h0, "ce_guard_c16");
    push_exp(17, 0, 4'h1, "ce_guard_c17");
    repeat (5) ce_group();
    pad_i = 4'hA;
    push_exp(8, 3, 4'h0, "ce_dq_before");
    push_exp(9, 3, 4'hA, "ce_dq_first");
    push_exp(12, 3, 4'hA, "ce_dq_held");
    push_exp(13, 3, 4'h0, "ce_dq_after");
    ce_group();
    pad_i = 4'h0;
    repeat (3) ce_group();
    ce = 1'b1;
`ifdef PMOD_QSPI_IO_LOOPBACK_EN
    lb = 1'b1;
    dq_o = 4'h5;
    dq_t = 4'h0;
    pad_i = 4'hA;
    push_exp(1, 4, 4'hF, "lb_dq_t");
    push_exp(4, 3, 4'h5, "lb_dq_i");
    push_exp(6, 3, 4'h5, "lb_dq_i_held");
    tick(7);
    lb = 1'b0;
`endif
    for (int i = 0; i < 64 && sb.size() > 0; i++) tick(1);
    foreach (sb[i]) begin
      errors++;
      $display("FAIL %s never checked: expected %h at cycle %0d", sb[i].name, sb[i].exp, sb[i].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
